// File: rtl/cordic_arctg.sv
// Iterative vectoring-mode CORDIC: bearing atan(y/x) in Q8.8 degrees from a peak sample.
// One micro-rotation per clock; y==0 / x==0 inputs force exact 0 / 90 degree results.
module cordic_arctg #(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  en_arctg,
    input  logic [23:0] max_date_adc,
    output logic        busy,
    output logic        angle_valid,
    output logic [15:0] angle_deg,
    output logic        undet,
    output logic [13:0] magnitude,
    output logic        overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
    typedef enum logic [1:0] {BP_NONE, BP_ZERO, BP_NINETY} bypass_t;

    localparam logic signed [16:0] ANGLE_MAX = 17'sd23040;  // 90.0 deg in Q8.8
    localparam logic [3:0]         LAST_IDX  = 4'(ITER - 1);

    state_t             state;
    bypass_t            bypass;
    logic signed [13:0] xr, yr;
    logic signed [16:0] z;
    logic [3:0]         i;

    logic [11:0]        x_in, y_in;
    logic               go, und, strobe;
    logic signed [13:0] x_sh, y_sh;
    logic signed [16:0] atan_i;
    logic [15:0]        z_clamped;

    function automatic logic signed [16:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_rom = 17'sd11520;
            4'd1:    atan_rom = 17'sd6801;
            4'd2:    atan_rom = 17'sd3593;
            4'd3:    atan_rom = 17'sd1824;
            4'd4:    atan_rom = 17'sd916;
            4'd5:    atan_rom = 17'sd458;
            4'd6:    atan_rom = 17'sd229;
            4'd7:    atan_rom = 17'sd115;
            4'd8:    atan_rom = 17'sd57;
            4'd9:    atan_rom = 17'sd29;
            4'd10:   atan_rom = 17'sd14;
            4'd11:   atan_rom = 17'sd7;
            default: atan_rom = 17'sd0;
        endcase
    endfunction

    assign x_in   = max_date_adc[23:12];
    assign y_in   = max_date_adc[11:0];
    assign go     = (en_arctg == 2'b11);
    assign und    = (en_arctg == 2'b01);
    assign strobe = go || und;
    assign x_sh   = xr >>> i;
    assign y_sh   = yr >>> i;
    assign atan_i = atan_rom(i);

    // The accumulated angle can overshoot slightly past either end of the quadrant.
    always_comb begin
        z_clamped = z[15:0];
        if (z[16])
            z_clamped = 16'h0000;
        else if (z > ANGLE_MAX)
            z_clamped = 16'h5A00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bypass      <= BP_NONE;
            xr          <= '0;
            yr          <= '0;
            z           <= '0;
            i           <= '0;
            busy        <= 1'b0;
            angle_valid <= 1'b0;
            angle_deg   <= '0;
            undet       <= 1'b0;
            magnitude   <= '0;
            overrun     <= 1'b0;
        end else begin
            angle_valid <= 1'b0;
            if (state != S_IDLE && strobe)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (go) begin
                        xr    <= {2'b00, x_in};
                        yr    <= {2'b00, y_in};
                        z     <= '0;
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= S_ITER;
                        if (y_in == 12'd0)
                            bypass <= BP_ZERO;
                        else if (x_in == 12'd0)
                            bypass <= BP_NINETY;
                        else
                            bypass <= BP_NONE;
                    end else if (und) begin
                        angle_valid <= 1'b1;
                        undet       <= 1'b1;
                        angle_deg   <= '0;
                        magnitude   <= '0;
                    end
                end

                S_ITER: begin
                    // Rotate toward the x axis; sign of y picks the direction.
                    if (!yr[13]) begin
                        xr <= xr + y_sh;
                        yr <= yr - x_sh;
                        z  <= z + atan_i;
                    end else begin
                        xr <= xr - y_sh;
                        yr <= yr + x_sh;
                        z  <= z - atan_i;
                    end
                    if (i == LAST_IDX)
                        state <= S_DONE;
                    else
                        i <= i + 4'd1;
                end

                S_DONE: begin
                    angle_valid <= 1'b1;
                    undet       <= 1'b0;
                    busy        <= 1'b0;
                    magnitude   <= $unsigned(xr);
                    state       <= S_IDLE;
                    case (bypass)
                        BP_ZERO:   angle_deg <= 16'h0000;
                        BP_NINETY: angle_deg <= 16'h5A00;
                        default:   angle_deg <= z_clamped;
                    endcase
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arctg.sv
// Scoreboard bench for cordic_arctg: expected results queued at stimulus time,
// popped and compared by a monitor whenever angle_valid pulses.
module tb_cordic_arctg;

    localparam int ITER = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en_arctg = 2'b00;
    logic [23:0] max_date_adc = '0;
    logic        busy, angle_valid, undet, overrun;
    logic [15:0] angle_deg;
    logic [13:0] magnitude;

    cordic_arctg #(.ITER(ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_arctg     (en_arctg),
        .max_date_adc (max_date_adc),
        .busy         (busy),
        .angle_valid  (angle_valid),
        .angle_deg    (angle_deg),
        .undet        (undet),
        .magnitude    (magnitude),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        u;
        logic [15:0] ang;
        logic [13:0] mag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_bad = 0, n_out = 0;
    int   atan_tab[12] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7};

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_vec++;
        if (got < exp - tol || got > exp + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
                     tag, got, got, exp, exp, tol);
        end
    endtask

    // Reference: exact integer vectoring CORDIC, then bypass and clamp rules.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int xr, yr, z, xo;
        xr = x; yr = y; z = 0;
        for (int k = 0; k < ITER; k++) begin
            xo = xr;
            if (yr >= 0) begin
                xr = xr + (yr >>> k); yr = yr - (xo >>> k); z = z + atan_tab[k];
            end else begin
                xr = xr - (yr >>> k); yr = yr + (xo >>> k); z = z - atan_tab[k];
            end
        end
        e.u   = 1'b0;
        e.mag = 14'(xr);
        if (y == 0)          e.ang = 16'h0000;
        else if (x == 0)     e.ang = 16'h5A00;
        else if (z < 0)      e.ang = 16'h0000;
        else if (z > 23040)  e.ang = 16'h5A00;
        else                 e.ang = 16'(z);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && angle_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                n_out++;
                check("undet", int'(undet), int'(mon_e.u));
                check("angle", int'(angle_deg), int'(mon_e.ang));
                check("mag", int'(magnitude), int'(mon_e.mag));
            end
        end
    end

    // Caller is at a negedge; strobe is held for exactly one clock.
    task automatic send(input int x, input int y);
        en_arctg     = 2'b11;
        max_date_adc = {12'(x), 12'(y)};
        sb.push_back(model(x, y));
        @(negedge clk);
        en_arctg = 2'b00;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 1;
        while (!angle_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!angle_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_drain"}, sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        int   c, outs, pulses;
        exp_t e;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", int'(angle_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_angle", int'(angle_deg), 0);
        check("rst_mag", int'(magnitude), 0);
        check("rst_undet", int'(undet), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk);

        // 45 degrees: latency and busy window; result ends within the last-step residual.
        send(256, 256);
        check("t1_busy", int'(busy), 1);
        wait_valid("t1", c);
        check("t1_latency", c, ITER + 2);
        check("t1_busy_clr", int'(busy), 0);
        check("t1_ang_approx", int'(angle_deg), 16'h2D00, 8);
        // A strobe in the pulse cycle must be accepted.
        send(3000, 1000);
        drain("t1b");
        repeat (3) @(negedge clk);
        e = model(3000, 1000);
        check("hold_angle", int'(angle_deg), int'(e.ang));
        check("hold_valid", int'(angle_valid), 0);

        // 30 degrees, magnitude near K*sqrt(x^2+y^2) = 7787.
        send(4095, 2364);
        wait_valid("t2", c);
        check("t2_ang_approx", int'(angle_deg), 16'h1E00, 8);
        check("t2_mag_approx", int'(magnitude), 7787, 20);
        drain("t2");

        // Axis bypasses and the all-zero sample.
        send(12'h800, 0);     drain("t3a");
        send(0, 12'h800);     drain("t3b");
        send(0, 0);           drain("t3c");
        send(12'h001, 12'hFFF); drain("t3d");

        // Undetermined frame: one-cycle latency, never busy.
        en_arctg = 2'b01;
        sb.push_back('{1'b1, 16'h0000, 14'h0000});
        @(negedge clk);
        en_arctg = 2'b00;
        check("t4_valid", int'(angle_valid), 1);
        check("t4_busy", int'(busy), 0);
        @(negedge clk);
        check("t4_valid_drop", int'(angle_valid), 0);
        check("t4_busy2", int'(busy), 0);
        drain("t4");

        // Reserved code does nothing.
        en_arctg = 2'b10;
        @(negedge clk);
        en_arctg = 2'b00;
        repeat (4) @(negedge clk);
        check("t4r_busy", int'(busy), 0);
        check("t4r_overrun", int'(overrun), 0);

        // Second strobe three cycles into a computation.
        outs = n_out;
        send(1000, 2000);
        repeat (2) @(negedge clk);
        en_arctg = 2'b11;
        max_date_adc = {12'd50, 12'd3000};
        @(negedge clk);
        en_arctg = 2'b00;
        drain("t5");
        repeat (20) @(negedge clk);
        check("t5_overrun", int'(overrun), 1);
        check("t5_results", n_out - outs, 1);

        // Reset while iteration 5 is in flight.
        send(2000, 1500);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check("t6_busy", int'(busy), 0);
        check("t6_angle", int'(angle_deg), 0);
        check("t6_mag", int'(magnitude), 0);
        check("t6_overrun", int'(overrun), 0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (angle_valid) pulses++;
        end
        check("t6_no_valid", pulses, 0);
        send(1234, 567);
        drain("t6b");

        // Random points inside the non-overflowing range.
        for (int k = 0; k < 16; k++) begin
            send($urandom_range(0, 3072), $urandom_range(0, 3072));
            drain("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
